// File: rtl/clk_divider_prog.sv
// Programmable exact-ratio divider: divided clock plus one-cycle tick.
// Ports: clk100Mhz, rst_n, en, div_load, div_value -> clk_out, tick, div_active, load_pending, load_err.
module clk_divider_prog #(
    parameter int WIDTH       = 23,
    parameter int DEFAULT_DIV = 3125000
) (
    input  logic             clk100Mhz,
    input  logic             rst_n,
    input  logic             en,
    input  logic             div_load,
    input  logic [WIDTH-1:0] div_value,
    output logic             clk_out,
    output logic             tick,
    output logic [WIDTH-1:0] div_active,
    output logic             load_pending,
    output logic             load_err
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             pend_v_q, pend_v_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             err_q, err_d;

    logic             wrap;
    logic             load_ok;
    logic [WIDTH-1:0] cnt_nxt;
    logic [WIDTH-1:0] div_nxt;

    assign wrap    = (cnt_q == div_q - WIDTH'(1));
    assign load_ok = div_load && (div_value != '0);

    always_comb begin
        cnt_d    = cnt_q;
        div_d    = div_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        clk_d    = clk_q;
        tick_d   = 1'b0;
        err_d    = div_load && (div_value == '0);
        cnt_nxt  = cnt_q;
        div_nxt  = div_q;

        if (en) begin
            if (wrap) begin
                // Period boundary: a load arriving now beats an older pending one.
                cnt_nxt  = '0;
                div_nxt  = load_ok  ? div_value :
                           pend_v_q ? pend_q    : div_q;
                pend_v_d = 1'b0;
            end else begin
                cnt_nxt = cnt_q + WIDTH'(1);
                if (load_ok) begin
                    pend_d   = div_value;
                    pend_v_d = 1'b1;
                end
            end
            cnt_d  = cnt_nxt;
            div_d  = div_nxt;
            tick_d = wrap;
            // High window judged against the divisor of the period being entered.
            clk_d  = (cnt_nxt < (div_nxt >> 1));
        end else if (load_ok) begin
            div_d    = div_value;
            cnt_d    = '0;
            pend_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk100Mhz or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            div_q    <= WIDTH'(DEFAULT_DIV);
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            clk_q    <= 1'b0;
            tick_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            clk_q    <= clk_d;
            tick_q   <= tick_d;
            err_q    <= err_d;
        end
    end

    assign clk_out      = clk_q;
    assign tick         = tick_q;
    assign div_active   = div_q;
    assign load_pending = pend_v_q;
    assign load_err     = err_q;

endmodule

// File: tb/tb_clk_divider_prog.sv
// Directed bench for clk_divider_prog: DUT a (D=4 default), DUT b (3-bit, D=5 default).
// Expected values are hand-derived per clock edge.
module tb_clk_divider_prog;

    logic        clk100Mhz;
    logic        rst_n;
    logic        en_a, ld_a;
    logic [22:0] val_a;
    logic        clk_a, tick_a, pend_a, err_a;
    logic [22:0] act_a;
    logic        en_b, ld_b;
    logic [2:0]  val_b;
    logic        clk_b, tick_b, pend_b, err_b;
    logic [2:0]  act_b;

    int n_vec;
    int n_err;

    clk_divider_prog #(.WIDTH(23), .DEFAULT_DIV(4)) u_dut_a (
        .clk100Mhz    (clk100Mhz),
        .rst_n        (rst_n),
        .en           (en_a),
        .div_load     (ld_a),
        .div_value    (val_a),
        .clk_out      (clk_a),
        .tick         (tick_a),
        .div_active   (act_a),
        .load_pending (pend_a),
        .load_err     (err_a)
    );

    clk_divider_prog #(.WIDTH(3), .DEFAULT_DIV(5)) u_dut_b (
        .clk100Mhz    (clk100Mhz),
        .rst_n        (rst_n),
        .en           (en_b),
        .div_load     (ld_b),
        .div_value    (val_b),
        .clk_out      (clk_b),
        .tick         (tick_b),
        .div_active   (act_b),
        .load_pending (pend_b),
        .load_err     (err_b)
    );

    initial clk100Mhz = 1'b0;
    always #5 clk100Mhz = ~clk100Mhz;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk100Mhz);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        en_a  = 1'b0; ld_a = 1'b0; val_a = '0;
        en_b  = 1'b0; ld_b = 1'b0; val_b = '0;

        #23;
        chk("rst_clk",  32'(clk_a),  0);
        chk("rst_tick", 32'(tick_a), 0);
        chk("rst_act",  32'(act_a),  4);
        chk("rst_pend", 32'(pend_a), 0);
        chk("rst_err",  32'(err_a),  0);
        chk("rst_act_b", 32'(act_b), 5);

        step();
        rst_n = 1'b1;
        en_a  = 1'b1;

        // D=4: 1,0,0,1 repeating after the short first window
        for (int i = 1; i <= 12; i++) begin
            step();
            chk("a4_clk",  32'(clk_a),  32'((i % 4 == 0) || (i % 4 == 1)));
            chk("a4_tick", 32'(tick_a), 32'(i % 4 == 0));
        end
        chk("a4_act", 32'(act_a), 4);

        // load 6 at cnt=1
        step();
        ld_a = 1'b1; val_a = 23'd6;
        step();
        ld_a = 1'b0;
        chk("ld6_pend", 32'(pend_a), 1);
        chk("ld6_act",  32'(act_a),  4);
        step();
        step();
        chk("ld6_wrap_act",  32'(act_a),  6);
        chk("ld6_wrap_pend", 32'(pend_a), 0);
        chk("ld6_wrap_tick", 32'(tick_a), 1);
        chk("ld6_wrap_clk",  32'(clk_a),  1);
        for (int e = 17; e <= 27; e++) begin
            step();
            chk("d6_clk",  32'(clk_a),  32'((e - 16) % 6 < 3));
            chk("d6_tick", 32'(tick_a), 32'((e - 16) % 6 == 0));
        end

        // 6 then 8 before the wrap: 8 wins
        step();
        step();
        ld_a = 1'b1; val_a = 23'd6;
        step();
        val_a = 23'd8;
        step();
        ld_a = 1'b0;
        chk("ld8_pend", 32'(pend_a), 1);
        chk("ld8_act",  32'(act_a),  6);
        step();
        step();
        step();
        chk("ld8_act2", 32'(act_a),  8);
        chk("ld8_tick", 32'(tick_a), 1);
        chk("ld8_pend2", 32'(pend_a), 0);
        for (int e = 35; e <= 42; e++) begin
            step();
            chk("d8_clk",  32'(clk_a),  32'((e - 34) % 8 < 4));
            chk("d8_tick", 32'(tick_a), 32'((e - 34) % 8 == 0));
        end

        // zero load rejected
        ld_a = 1'b1; val_a = 23'd0;
        step();
        ld_a = 1'b0;
        chk("ld0_err",  32'(err_a),  1);
        chk("ld0_act",  32'(act_a),  8);
        chk("ld0_pend", 32'(pend_a), 0);
        step();
        chk("ld0_err_off", 32'(err_a), 0);

        // freeze at cnt=2 for 10 cycles
        en_a = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("hold_clk",  32'(clk_a),  1);
            chk("hold_tick", 32'(tick_a), 0);
        end
        en_a = 1'b1;
        step();
        chk("resume_clk3", 32'(clk_a), 1);
        step();
        chk("resume_clk4", 32'(clk_a), 0);
        step();
        step();
        step();
        chk("resume_tick7", 32'(tick_a), 0);
        step();
        chk("resume_wrap", 32'(tick_a), 1);
        chk("resume_clk0", 32'(clk_a),  1);

        // load 3 while disabled
        step();
        en_a = 1'b0;
        ld_a = 1'b1; val_a = 23'd3;
        step();
        ld_a = 1'b0;
        chk("dis3_act",  32'(act_a),  3);
        chk("dis3_pend", 32'(pend_a), 0);
        chk("dis3_clk",  32'(clk_a),  1);
        en_a = 1'b1;
        step();
        chk("d3_tick1", 32'(tick_a), 0);
        chk("d3_clk1",  32'(clk_a),  0);
        step();
        chk("d3_tick2", 32'(tick_a), 0);
        step();
        chk("d3_tick3", 32'(tick_a), 1);
        chk("d3_clk3",  32'(clk_a),  1);

        // pending, then disabled load overrides it
        ld_a = 1'b1; val_a = 23'd5;
        step();
        chk("p5_pend", 32'(pend_a), 1);
        en_a = 1'b0;
        val_a = 23'd2;
        step();
        ld_a = 1'b0;
        chk("dis2_act",  32'(act_a),  2);
        chk("dis2_pend", 32'(pend_a), 0);
        en_a = 1'b1;
        step();
        chk("d2_tick1", 32'(tick_a), 0);
        step();
        chk("d2_tick2", 32'(tick_a), 1);
        chk("d2_act",   32'(act_a),  2);
        chk("d2_clk",   32'(clk_a),  1);

        // set up D=10 with a pending 7, then reset mid-period
        ld_a = 1'b1; val_a = 23'd10;
        step();
        ld_a = 1'b0;
        chk("p10_pend", 32'(pend_a), 1);
        step();
        chk("p10_act",  32'(act_a),  10);
        chk("p10_tick", 32'(tick_a), 1);
        step();
        ld_a = 1'b1; val_a = 23'd7;
        step();
        ld_a = 1'b0;
        chk("p7_pend", 32'(pend_a), 1);
        chk("p7_clk",  32'(clk_a),  1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_clk",  32'(clk_a),  0);
        chk("arst_tick", 32'(tick_a), 0);
        chk("arst_act",  32'(act_a),  4);
        chk("arst_pend", 32'(pend_a), 0);
        chk("arst_err",  32'(err_a),  0);
        step();
        rst_n = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            chk("post_tick", 32'(tick_a), 32'(i % 4 == 0));
            chk("post_act",  32'(act_a),  4);
        end
        chk("post_pend", 32'(pend_a), 0);
        en_a = 1'b0;

        // DUT b: D=5, 2 high / 3 low
        en_b = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            step();
            chk("b5_clk_first",  32'(clk_b),  32'(e == 1));
            chk("b5_tick_first", 32'(tick_b), 0);
        end
        for (int e = 5; e <= 14; e++) begin
            step();
            chk("b5_clk",  32'(clk_b),  32'((e - 5) % 5 < 2));
            chk("b5_tick", 32'(tick_b), 32'((e - 5) % 5 == 0));
        end

        // load 1 on the wrap cycle
        ld_b = 1'b1; val_b = 3'd1;
        step();
        ld_b = 1'b0;
        chk("b1_act",  32'(act_b),  1);
        chk("b1_tick", 32'(tick_b), 1);
        chk("b1_clk",  32'(clk_b),  0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("b1_tick_run", 32'(tick_b), 1);
            chk("b1_clk_run",  32'(clk_b),  0);
        end

        // maximum divisor 2^3-1
        ld_b = 1'b1; val_b = 3'd7;
        step();
        ld_b = 1'b0;
        chk("b7_act",  32'(act_b),  7);
        chk("b7_tick", 32'(tick_b), 1);
        chk("b7_clk",  32'(clk_b),  1);
        for (int e = 21; e <= 34; e++) begin
            step();
            chk("b7_clk_run",  32'(clk_b),  32'((e - 20) % 7 < 3));
            chk("b7_tick_run", 32'(tick_b), 32'((e - 20) % 7 == 0));
        end
        chk("b7_pend", 32'(pend_b), 0);
        chk("b7_err",  32'(err_b),  0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/clk_divider_prog.md
Name: clk_divider_prog

Overview:
- Exact-ratio, runtime-programmable clock-enable/divided-clock generator. Successor to the fixed power-of-two divider.
- Divides clk100Mhz by any integer D (not only 2^n). Default D gives exactly 32 Hz from 100 MHz.
- Outputs:
  - a near-50% duty divided clock, for LEDs and display scan;
  - a one-cycle tick strobe, for step/timer logic running in the clk100Mhz domain.
- Divisor changes are glitch-free: they take effect only at a period boundary.

Parameters:
- WIDTH, 23, width of the counter and the divisor.
- DEFAULT_DIV, 3125000, divisor loaded at reset. Must satisfy 1 ≤ DEFAULT_DIV ≤ 2^WIDTH-1.

Ports:
- clk100Mhz  input  1  system clock, 100 MHz, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  count enable. When low, the divider freezes.
- div_load  input  1  one-cycle strobe; captures div_value.
- div_value  input  WIDTH  requested divisor D.
- clk_out  output  1  divided clock, registered.
- tick  output  1  one-cycle pulse per period, registered.
- div_active  output  WIDTH  divisor currently in use.
- load_pending  output  1  a captured divisor is waiting for the next wrap.
- load_err  output  1  one-cycle pulse when div_load is rejected (div_value = 0).

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (rst_n, clock clk100Mhz). While reset is asserted:
  - cnt=0, div_active=DEFAULT_DIV, pending divisor=0;
  - clk_out=0, tick=0, load_pending=0, load_err=0.
  - Reset asserted mid-period aborts the period immediately; no pending load survives.
- Counter cnt (WIDTH bits) runs 0..D-1, where D = div_active. H = D>>1 (high-window length).
- Enabled cycle (en=1):
  - cnt_next = (cnt == D-1) ? 0 : cnt+1
  - tick <= (cnt == D-1)
  - clk_out <= (cnt_next < H)
- tick, the clk_out rising edge and cnt=0 are visible in the same cycle. Period is D cycles.
- Duty cycle:
  - clk_out is high for H cycles and low for D-H cycles; odd D gives the extra cycle to low.
  - D=1: tick is high every enabled cycle and clk_out stays 0.
- First period after reset: cnt starts at 0, so the first high window is H-1 cycles. This is permitted; all later periods are exact.
- en=0: cnt, clk_out and div_active hold; tick=0 on the next edge. Loads are still accepted (see below).
- Divisor load, when div_load=1:
  - div_value=0: the load is ignored and load_err pulses for one cycle; pending state is unchanged.
  - en=0: div_active <= div_value and cnt <= 0 immediately. clk_out holds; load_pending stays 0.
  - en=1 and this is not a wrap cycle: the value goes to the pending register and load_pending <= 1.
  - en=1 and a wrap cycle (cnt == D-1): div_active <= div_value at this wrap. The new period starts with the new D; load_pending <= 0.
- Applying a pending value: at the next enabled wrap, div_active <= pending and load_pending <= 0.
  - clk_out for that cycle is evaluated with the new H (cnt_next=0). No runt pulse is produced.
- A second load before the wrap overwrites the pending value; the last load wins.
- A valid load while en=0 and load_pending=1 applies div_value directly and clears load_pending.
- Wrap arithmetic:
  - All compares are unsigned WIDTH-bit; D-1 is computed at WIDTH bits.
  - D=2^WIDTH-1 is legal; cnt never overflows.
- Latency: div_active updates 1 cycle after the accepting edge. Outputs are fully registered; there are no combinational paths from inputs to outputs.

Test Plan:
- DEFAULT_DIV=4, en=1 after reset → clk_out: 0,1,0,0 then repeating 1,1,0,0. tick high on cycles 4, 8, 12 (cnt=0 each time). div_active=4.
- DEFAULT_DIV=5 → steady state clk_out is 2 high / 3 low; tick every 5 cycles. Then load 1 at a wrap → tick every cycle, clk_out=0.
- D=4, div_load with 6 at cnt=1 → load_pending=1; the current period ends at 4 cycles. Next periods are 6 cycles, 3 high / 3 low; load_pending clears at the wrap. No pulse shorter than 2 cycles appears.
- Loads of 6 then 8 before the wrap → only 8 is applied. Load of 0 → load_err pulses once and div_active is unchanged.
- en=0 for 10 cycles at cnt=2 → cnt, clk_out hold and no tick. Load of 3 while disabled → div_active=3, cnt=0; after re-enable, tick arrives 3 cycles later.
- rst_n pulled low mid-period with load_pending=1 → all outputs reset immediately without waiting for a clock edge. div_active=DEFAULT_DIV, load_pending=0, and the pending value is discarded.
